// File: rtl/ddr_phy_pkg.sv
// Shared types and helpers for the DDR output PHY.
package ddr_phy_pkg;

  typedef enum logic [0:0] {
    IDLE_HOLD  = 1'b0,
    IDLE_CONST = 1'b1
  } idle_mode_e;

  // FIFO pointers carry one extra wrap bit to tell full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ddr_out_serdes_if.sv
// Beat-pair valid/ready channel into the DDR output PHY.
interface ddr_out_serdes_if #(
  parameter int unsigned WIDTH = 8
);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_dp;
  logic [WIDTH-1:0] s_dn;

  modport master (
    output s_valid,
    output s_dp,
    output s_dn,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_dp,
    input  s_dn,
    output s_ready
  );

endinterface

// File: rtl/ddr_out_cell.sv
// Glitch-free dual-edge output register: out = rn ^ r1, r1/r2 at posedge, rn at negedge.
// Every pad transition comes from exactly one flop edge, so out never depends on clk directly.
module ddr_out_cell #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_dp,
  input  logic [W-1:0] i_dn,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r1;
  logic [W-1:0] r2;
  logic [W-1:0] rn;

  // In reset r1 and rn copy each other, so the output is 0 from whichever
  // edge first samples reset_n low and never glitches on the other edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r1 <= rn;
      r2 <= '0;
    end else begin
      r1 <= i_dp ^ rn;
      r2 <= i_dn;
    end
  end

  always_ff @(negedge clk) begin
    if (!reset_n) begin
      rn <= r1;
    end else begin
      rn <= r2 ^ r1;
    end
  end

  assign o_q = rn ^ r1;

endmodule

// File: rtl/ddr_out_serdes.sv
// DDR output PHY: beat FIFO, dual-edge pad/OE cells, idle policy, underrun flag, beat counter.
// Define DDR_STROBE_EN to add the strobe_o source-synchronous strobe output.
module ddr_out_serdes
  import ddr_phy_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter idle_mode_e       IDLE_MODE = IDLE_HOLD,
  parameter logic [WIDTH-1:0] IDLE_VAL  = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  ddr_out_serdes_if.slave   s_if,
  input  logic              flush,
  input  logic              clr_stat,
  output logic [WIDTH-1:0]  pad_o,
  output logic              pad_oe_o,
  output logic              busy_o,
  output logic              underrun_o,
  output logic [CNT_W-1:0]  beat_cnt_o
`ifdef DDR_STROBE_EN
  ,
  output logic              strobe_o
`endif
);

  localparam int unsigned      PTR_W     = ptr_w(DEPTH);
  localparam int unsigned      IDX_W     = PTR_W - 1;
  localparam logic [PTR_W-1:0] FULL_DIFF = PTR_W'(DEPTH);

  logic [WIDTH-1:0] r_mem_dp [DEPTH];
  logic [WIDTH-1:0] r_mem_dn [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             r_ready;
  logic             r_active;
  logic             r_underrun;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_last_dn;

  logic [PTR_W-1:0] w_wptr_d;
  logic [PTR_W-1:0] w_rptr_d;
  logic             w_empty;
  logic             w_full_d;
  logic             w_push;
  logic             w_active;
  logic             w_underrun_evt;
  logic [WIDTH-1:0] w_head_dp;
  logic [WIDTH-1:0] w_head_dn;
  logic [WIDTH-1:0] w_cell_dp;
  logic [WIDTH-1:0] w_cell_dn;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_active  = !w_empty && !flush;
  assign w_push    = s_if.s_valid && r_ready && !flush;
  assign w_head_dp = r_mem_dp[r_rptr[IDX_W-1:0]];
  assign w_head_dn = r_mem_dn[r_rptr[IDX_W-1:0]];

  // A pending beat that missed this edge means the pad went idle mid-stream.
  assign w_underrun_evt = !w_active && r_active && s_if.s_valid && !flush;

  always_comb begin
    w_wptr_d = r_wptr;
    w_rptr_d = r_rptr;
    if (flush) begin
      w_wptr_d = '0;
      w_rptr_d = '0;
    end else begin
      if (w_push) begin
        w_wptr_d = r_wptr + PTR_W'(1);
      end
      if (w_active) begin
        w_rptr_d = r_rptr + PTR_W'(1);
      end
    end
  end

  assign w_full_d = ((w_wptr_d ^ w_rptr_d) == FULL_DIFF);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_dp[r_wptr[IDX_W-1:0]] <= s_if.s_dp;
      r_mem_dn[r_wptr[IDX_W-1:0]] <= s_if.s_dn;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ready    <= 1'b0;
      r_active   <= 1'b0;
      r_underrun <= 1'b0;
      r_cnt      <= '0;
      r_last_dn  <= '0;
    end else begin
      r_wptr   <= w_wptr_d;
      r_rptr   <= w_rptr_d;
      r_ready  <= !w_full_d;
      r_active <= w_active;
      if (w_underrun_evt) begin
        r_underrun <= 1'b1;
      end else if (clr_stat) begin
        r_underrun <= 1'b0;
      end
      if (clr_stat) begin
        r_cnt <= w_active ? CNT_W'(1) : '0;
      end else if (w_active) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_active) begin
        r_last_dn <= w_head_dn;
      end
    end
  end

  always_comb begin
    w_cell_dp = w_head_dp;
    w_cell_dn = w_head_dn;
    if (!w_active) begin
      if (IDLE_MODE == IDLE_CONST) begin
        w_cell_dp = IDLE_VAL;
        w_cell_dn = IDLE_VAL;
      end else begin
        w_cell_dp = r_last_dn;
        w_cell_dn = r_last_dn;
      end
    end
  end

  ddr_out_cell #(
    .W (WIDTH)
  ) u_data_cell (
    .clk     (clk),
    .reset_n (reset_n),
    .i_dp    (w_cell_dp),
    .i_dn    (w_cell_dn),
    .o_q     (pad_o)
  );

  // Same value on both halves keeps OE stable across the negedge.
  ddr_out_cell #(
    .W (1)
  ) u_oe_cell (
    .clk     (clk),
    .reset_n (reset_n),
    .i_dp    (w_active),
    .i_dn    (w_active),
    .o_q     (pad_oe_o)
  );

`ifdef DDR_STROBE_EN
  ddr_out_cell #(
    .W (1)
  ) u_strobe_cell (
    .clk     (clk),
    .reset_n (reset_n),
    .i_dp    (w_active),
    .i_dn    (1'b0),
    .o_q     (strobe_o)
  );
`endif

  assign s_if.s_ready = r_ready;
  assign busy_o       = !w_empty || r_active;
  assign underrun_o   = r_underrun;
  assign beat_cnt_o   = r_cnt;

endmodule

// File: tb/tb_ddr_out_serdes.sv
// Bench for ddr_out_serdes: IDLE_HOLD and IDLE_CONST instances share stimulus and a queue model.
// Strobe checks are included when DDR_STROBE_EN is defined.
module tb_ddr_out_serdes;
  import ddr_phy_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         valid;
  logic [W-1:0] dp;
  logic [W-1:0] dn;
  logic         flush;
  logic         clr_stat;

  logic [W-1:0] pad_h, pad_c;
  logic         oe_h, oe_c, busy_h, busy_c, ur_h, ur_c;
  logic [15:0]  cnt_h, cnt_c;
`ifdef DDR_STROBE_EN
  logic         stb_h, stb_c;
`endif

  ddr_out_serdes_if #(.WIDTH(W)) if_h ();
  ddr_out_serdes_if #(.WIDTH(W)) if_c ();

  assign if_h.s_valid = valid;
  assign if_h.s_dp    = dp;
  assign if_h.s_dn    = dn;
  assign if_c.s_valid = valid;
  assign if_c.s_dp    = dp;
  assign if_c.s_dn    = dn;

  ddr_out_serdes #(
    .WIDTH(W), .DEPTH(D), .IDLE_MODE(IDLE_HOLD), .IDLE_VAL(8'h00), .CNT_W(16)
  ) u_dut_hold (
    .clk(clk), .reset_n(reset_n), .s_if(if_h), .flush(flush), .clr_stat(clr_stat),
    .pad_o(pad_h), .pad_oe_o(oe_h), .busy_o(busy_h), .underrun_o(ur_h), .beat_cnt_o(cnt_h)
`ifdef DDR_STROBE_EN
    , .strobe_o(stb_h)
`endif
  );

  ddr_out_serdes #(
    .WIDTH(W), .DEPTH(D), .IDLE_MODE(IDLE_CONST), .IDLE_VAL(8'hFF), .CNT_W(16)
  ) u_dut_const (
    .clk(clk), .reset_n(reset_n), .s_if(if_c), .flush(flush), .clr_stat(clr_stat),
    .pad_o(pad_c), .pad_oe_o(oe_c), .busy_o(busy_c), .underrun_o(ur_c), .beat_cnt_o(cnt_c)
`ifdef DDR_STROBE_EN
    , .strobe_o(stb_c)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;

  // Reference model: a plain queue of pending beats plus the observable flags.
  logic [15:0] m_q[$];
  bit          m_ready = 0;
  bit          m_act = 0;
  bit          m_ur = 0;
  logic [15:0] m_cnt = '0;
  logic [7:0]  m_last = '0;
  logic [15:0] m_cur = '0;

  // Values sampled inside step for later table comparison.
  logic       s_oe, s_busy, s_ur;
  logic [7:0] s_hi, s_lo;
  logic [15:0] s_cnt;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", name, $time, act, exp);
    end
  endfunction

  task automatic step(input bit rst, input bit v, input logic [7:0] d_p, input logic [7:0] d_n,
                      input bit fl, input bit clr);
    bit prev;
    logic [7:0] e_hi_h, e_lo_h, e_hi_c, e_lo_c;
    reset_n  = rst;
    valid    = v;
    dp       = d_p;
    dn       = d_n;
    flush    = fl;
    clr_stat = clr;
    @(posedge clk);
    if (!rst) begin
      m_q.delete();
      m_ready = 0;
      m_act   = 0;
      m_ur    = 0;
      m_cnt   = '0;
      m_last  = '0;
      e_hi_h  = 8'h00;
      e_lo_h  = 8'h00;
      e_hi_c  = 8'h00;
      e_lo_c  = 8'h00;
    end else begin
      prev  = m_act;
      m_act = (m_q.size() != 0) && !fl;
      if (fl) begin
        m_q.delete();
      end else begin
        if (m_act) m_cur = m_q.pop_front();
        if (v && m_ready) begin
          m_q.push_back({d_p, d_n});
          n_acc++;
        end
      end
      if (!m_act && prev && v && !fl) m_ur = 1;
      else if (clr) m_ur = 0;
      if (clr) m_cnt = m_act ? 16'd1 : 16'd0;
      else if (m_act) m_cnt = m_cnt + 16'd1;
      m_ready = (m_q.size() < D);
      e_hi_h = m_act ? m_cur[15:8] : m_last;
      e_lo_h = m_act ? m_cur[7:0]  : m_last;
      e_hi_c = m_act ? m_cur[15:8] : 8'hFF;
      e_lo_c = m_act ? m_cur[7:0]  : 8'hFF;
      if (m_act) m_last = m_cur[7:0];
    end
    #1;
    s_oe = oe_h; s_busy = busy_h; s_ur = ur_h; s_cnt = cnt_h; s_hi = pad_h;
    chk("oe_hi_hold", oe_h, m_act);
    chk("oe_hi_const", oe_c, m_act);
    chk("busy_hold", busy_h, (m_q.size() != 0) || m_act);
    chk("busy_const", busy_c, (m_q.size() != 0) || m_act);
    chk("ready_hold", if_h.s_ready, m_ready);
    chk("ready_const", if_c.s_ready, m_ready);
    chk("underrun_hold", ur_h, m_ur);
    chk("underrun_const", ur_c, m_ur);
    chk("cnt_hold", cnt_h, m_cnt);
    chk("cnt_const", cnt_c, m_cnt);
    if (rst) begin
      chk("pad_hi_hold", pad_h, e_hi_h);
      chk("pad_hi_const", pad_c, e_hi_c);
`ifdef DDR_STROBE_EN
      chk("strobe_hi", stb_h, m_act);
`endif
    end
    @(negedge clk);
    #1;
    s_lo = pad_h;
    chk("pad_lo_hold", pad_h, e_lo_h);
    chk("pad_lo_const", pad_c, e_lo_c);
    chk("oe_lo_hold", oe_h, m_act);
`ifdef DDR_STROBE_EN
    chk("strobe_lo", stb_h, 1'b0);
`endif
  endtask

  typedef struct {
    bit         rst_n;
    bit         v;
    logic [7:0] dp;
    logic [7:0] dn;
    bit         fl;
    bit         clr;
    bit         oe;
    logic [7:0] hi;
    logic [7:0] lo;
    bit         ur;
    int         cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int acc0, run, max_run, ready_low;
    reset_n = 1'b0; valid = 1'b0; dp = '0; dn = '0; flush = 1'b0; clr_stat = 1'b0;

    //         rst v  dp     dn     fl clr oe hi     lo     ur cnt
    tbl[0]  = '{1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0};
    tbl[1]  = '{1, 1, 8'hA5, 8'h3C, 0, 0, 0, 8'h00, 8'h00, 0, 0};
    tbl[2]  = '{1, 0, 8'h00, 8'h00, 0, 0, 1, 8'hA5, 8'h3C, 0, 1};
    tbl[3]  = '{1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h3C, 8'h3C, 0, 1};
    tbl[4]  = '{1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h3C, 8'h3C, 0, 1};
    tbl[5]  = '{1, 1, 8'h33, 8'h44, 0, 0, 1, 8'h11, 8'h22, 0, 2};
    tbl[6]  = '{1, 0, 8'h00, 8'h00, 0, 0, 1, 8'h33, 8'h44, 0, 3};
    tbl[7]  = '{1, 1, 8'h55, 8'h66, 0, 0, 0, 8'h44, 8'h44, 1, 3};
    tbl[8]  = '{1, 0, 8'h00, 8'h00, 0, 1, 1, 8'h55, 8'h66, 0, 1};
    tbl[9]  = '{1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h66, 8'h66, 0, 1};
    tbl[10] = '{1, 1, 8'h77, 8'h88, 1, 0, 0, 8'h66, 8'h66, 0, 1};
    tbl[11] = '{1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h66, 8'h66, 0, 1};

    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 8'h00, 0, 0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst_n, tbl[i].v, tbl[i].dp, tbl[i].dn, tbl[i].fl, tbl[i].clr);
      chk($sformatf("tbl%0d_oe", i), s_oe, tbl[i].oe);
      chk($sformatf("tbl%0d_hi", i), s_hi, tbl[i].hi);
      chk($sformatf("tbl%0d_lo", i), s_lo, tbl[i].lo);
      chk($sformatf("tbl%0d_ur", i), s_ur, tbl[i].ur);
      chk($sformatf("tbl%0d_cnt", i), s_cnt, tbl[i].cnt);
    end

    // 16-beat burst with valid held.
    step(1, 0, 8'h00, 8'h00, 0, 1);
    acc0 = n_acc; run = 0; max_run = 0; ready_low = 0;
    for (int c = 0; c < 40 && (n_acc - acc0) < 16; c++) begin
      logic [7:0] b;
      b = 8'h10 + 8'(n_acc - acc0);
      if ((n_acc - acc0) > 0 && !if_h.s_ready) ready_low++;
      step(1, 1, b, ~b, 0, 0);
      run = s_oe ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    chk("burst_accepted", n_acc - acc0, 16);
    for (int c = 0; c < 4; c++) begin
      step(1, 0, 8'h00, 8'h00, 0, 0);
      run = s_oe ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    chk("burst_run", max_run, 16);
    chk("burst_ready_low", ready_low, 0);
    chk("burst_cnt", s_cnt, 16);
    chk("burst_ur", s_ur, 0);

    // Flush while streaming with a concurrent push.
    for (int c = 0; c < 4; c++) step(1, 1, 8'hC0 + 8'(c), 8'h0C + 8'(c), 0, 0);
    step(1, 1, 8'hEE, 8'hDD, 1, 0);
    chk("flush_busy", s_busy, 0);
    chk("flush_oe", s_oe, 0);
    chk("flush_ur", s_ur, 0);
    step(1, 0, 8'h00, 8'h00, 0, 0);
    chk("post_flush_oe", s_oe, 0);

    // Reset mid-burst.
    for (int c = 0; c < 3; c++) step(1, 1, 8'h5A + 8'(c), 8'hA5 - 8'(c), 0, 0);
    step(0, 1, 8'h99, 8'h98, 0, 0);
    chk("rst_pad_lo", s_lo, 8'h00);
    chk("rst_oe", s_oe, 0);
    chk("rst_busy", s_busy, 0);
    step(0, 0, 8'h00, 8'h00, 0, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 500; c++) begin
      bit r, v, f, k;
      r = ($urandom_range(99) != 0);
      v = ($urandom_range(9) < 7);
      f = ($urandom_range(49) == 0);
      k = ($urandom_range(19) == 0);
      step(r, v, 8'($urandom), 8'($urandom), f, k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
